// File: rtl/tb_pkg.sv
// Shared types and defaults for the tree-chopping game sequencer.
package tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int unsigned ROWS        = 10;
  localparam int unsigned COLLIDE_ROW = 6;

  localparam logic [ROWS-1:0] LEFT_INIT_DEF  = 10'b0111010;
  localparam logic [ROWS-1:0] RIGHT_INIT_DEF = 10'b0000101;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/tb_debounce.sv
// Release-triggered button debouncer: a one-cycle press after a long enough low hold.
module tb_debounce #(
  parameter int unsigned DEBOUNCE = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Count saturates while held; any release clears it and fires if it had saturated.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!btn_n) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else begin
      press_d = (cnt_q == CNT_MAX);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tb_game_seq.sv
// Game sequencer: buttons, IDLE/PLAY/OVER control, branches, score and timer updated on frame_tick.
// Define TB_LFSR_EN to draw branch bits from a 16-bit LFSR instead of the 6-bit generator.
module tb_game_seq import tb_pkg::*; #(
  parameter int unsigned     CLK_HZ       = 50000000,
  parameter int unsigned     DEBOUNCE     = 5000000,
  parameter int unsigned     GAME_SECONDS = 30,
  parameter logic [ROWS-1:0] LEFT_INIT    = LEFT_INIT_DEF,
  parameter logic [ROWS-1:0] RIGHT_INIT   = RIGHT_INIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            b1,
  input  logic            b2,
  input  logic            b3,
  input  logic            frame_tick,
  output logic [ROWS-1:0] left_branch,
  output logic [ROWS-1:0] right_branch,
  output logic            player_pos,
  output logic            game_over,
  output bcd_t            score_ones,
  output bcd_t            score_tens,
  output bcd_t            time_ones,
  output bcd_t            time_tens,
  output logic [1:0]      state
);

  localparam int unsigned PW = (CLK_HZ < 2) ? 1 : $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam bcd_t T_TENS_INIT = bcd_t'(GAME_SECONDS / 10);
  localparam bcd_t T_ONES_INIT = bcd_t'(GAME_SECONDS % 10);

`ifdef TB_LFSR_EN
  localparam int unsigned GEN_W = 16;
  localparam logic [GEN_W-1:0] GEN_SEED = 16'hACE1;
`else
  localparam int unsigned GEN_W = 6;
  localparam logic [GEN_W-1:0] GEN_SEED = 6'd34;
`endif

  logic press_l, press_r, press_rs;

  tb_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_l  (.clk(clk), .rst(rst), .btn_n(b1), .press(press_l));
  tb_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_r  (.clk(clk), .rst(rst), .btn_n(b2), .press(press_r));
  tb_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_rs (.clk(clk), .rst(rst), .btn_n(b3), .press(press_rs));

  state_e          state_q, state_d;
  logic [ROWS-1:0] left_q, left_d, right_q, right_d;
  logic            player_q, player_d, over_q, over_d;
  bcd_t            s_ones_q, s_ones_d, s_tens_q, s_tens_d;
  bcd_t            t_ones_q, t_ones_d, t_tens_q, t_tens_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            pend_v_q, pend_v_d, pend_s_q, pend_s_d;
  logic            chk_q, chk_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  logic rnd_c, chop_c, side_c, hit_c, t_zero_c;

  // Branch generator free-runs every clock; only rst reseeds it.
  always_comb begin
`ifdef TB_LFSR_EN
    gen_d = {gen_q[0] ^ gen_q[2] ^ gen_q[3] ^ gen_q[5], gen_q[15:1]};
`else
    gen_d = {gen_q[1:0], ~gen_q[5:2]};
`endif
  end

  assign rnd_c    = gen_q[0];
  assign chop_c   = press_l | press_r;
  assign side_c   = ~press_l;
  assign hit_c    = (left_q[COLLIDE_ROW] & ~player_q) | (right_q[COLLIDE_ROW] & player_q);
  assign t_zero_c = (t_tens_q == 4'd0) && (t_ones_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    right_d  = right_q;
    player_d = player_q;
    over_d   = over_q;
    s_ones_d = s_ones_q;
    s_tens_d = s_tens_q;
    t_ones_d = t_ones_q;
    t_tens_d = t_tens_q;
    presc_d  = '0;
    pend_v_d = pend_v_q;
    pend_s_d = pend_s_q;
    chk_d    = 1'b0;

    if (press_rs) begin
      state_d  = IDLE;
      left_d   = LEFT_INIT;
      right_d  = RIGHT_INIT;
      player_d = 1'b0;
      over_d   = 1'b0;
      s_ones_d = '0;
      s_tens_d = '0;
      t_ones_d = T_ONES_INIT;
      t_tens_d = T_TENS_INIT;
      pend_v_d = 1'b0;
      pend_s_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (chop_c) begin
            state_d  = PLAY;
            pend_v_d = 1'b1;
            pend_s_d = side_c;
          end
        end
        PLAY: begin
          // Collision is judged one cycle after the commit that caused it.
          if ((chk_q && hit_c) || t_zero_c) begin
            state_d  = OVER;
            over_d   = 1'b1;
            pend_v_d = 1'b0;
          end else begin
            presc_d = presc_q + PW'(1);
            if (presc_q == PRESC_MAX) begin
              presc_d = '0;
              if (t_ones_q == 4'd0) begin
                t_ones_d = 4'd9;
                t_tens_d = t_tens_q - 4'd1;
              end else begin
                t_ones_d = t_ones_q - 4'd1;
              end
            end
            if (frame_tick && pend_v_q) begin
              player_d = pend_s_q;
              left_d   = {left_q[ROWS-2:0], rnd_c};
              right_d  = {right_q[ROWS-2:0], ~rnd_c};
              pend_v_d = 1'b0;
              chk_d    = 1'b1;
              if (!(s_tens_q == 4'd9 && s_ones_q == 4'd9)) begin
                if (s_ones_q == 4'd9) begin
                  s_ones_d = '0;
                  s_tens_d = s_tens_q + 4'd1;
                end else begin
                  s_ones_d = s_ones_q + 4'd1;
                end
              end
            end else if (chop_c && !pend_v_q) begin
              pend_v_d = 1'b1;
              pend_s_d = side_c;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      left_q   <= LEFT_INIT;
      right_q  <= RIGHT_INIT;
      player_q <= 1'b0;
      over_q   <= 1'b0;
      s_ones_q <= '0;
      s_tens_q <= '0;
      t_ones_q <= T_ONES_INIT;
      t_tens_q <= T_TENS_INIT;
      presc_q  <= '0;
      pend_v_q <= 1'b0;
      pend_s_q <= 1'b0;
      chk_q    <= 1'b0;
      gen_q    <= GEN_SEED;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      player_q <= player_d;
      over_q   <= over_d;
      s_ones_q <= s_ones_d;
      s_tens_q <= s_tens_d;
      t_ones_q <= t_ones_d;
      t_tens_q <= t_tens_d;
      presc_q  <= presc_d;
      pend_v_q <= pend_v_d;
      pend_s_q <= pend_s_d;
      chk_q    <= chk_d;
      gen_q    <= gen_d;
    end
  end

  assign left_branch  = left_q;
  assign right_branch = right_q;
  assign player_pos   = player_q;
  assign game_over    = over_q;
  assign score_ones   = s_ones_q;
  assign score_tens   = s_tens_q;
  assign time_ones    = t_ones_q;
  assign time_tens    = t_tens_q;
  assign state        = state_q;

endmodule

// File: tb/tb_tb_game_seq.sv
// Bench for tb_game_seq: integer-level game model checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_tb_game_seq;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned DEB    = 4;
  localparam int unsigned GS     = 12;
  localparam logic [9:0]  L0     = 10'b0111010;
  localparam logic [9:0]  R0     = 10'b0000101;

`ifdef TB_LFSR_EN
  localparam int unsigned GW = 16;
  localparam logic [GW-1:0] GSEED = 16'hACE1;
`else
  localparam int unsigned GW = 6;
  localparam logic [GW-1:0] GSEED = 6'd34;
`endif

  logic clk = 1'b0;
  logic rst, b1, b2, b3, frame_tick;
  logic [9:0] left_branch, right_branch;
  logic player_pos, game_over;
  logic [3:0] score_ones, score_tens, time_ones, time_tens;
  logic [1:0] state;

  tb_game_seq #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE(DEB), .GAME_SECONDS(GS),
    .LEFT_INIT(L0), .RIGHT_INIT(R0)
  ) dut (
    .clk(clk), .rst(rst), .b1(b1), .b2(b2), .b3(b3), .frame_tick(frame_tick),
    .left_branch(left_branch), .right_branch(right_branch),
    .player_pos(player_pos), .game_over(game_over),
    .score_ones(score_ones), .score_tens(score_tens),
    .time_ones(time_ones), .time_tens(time_tens), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: state 0/1/2, score and time as plain integers.
  int         m_state, m_score, m_time, m_presc;
  logic [9:0] m_left, m_right;
  bit         m_player, m_over, m_pend, m_side, m_due;
  int         m_low[3];
  bit         m_pp[3];
  logic [GW-1:0] m_gen;

  task automatic restore_game();
    m_state = 0; m_score = 0; m_time = GS; m_presc = 0;
    m_left = L0; m_right = R0; m_player = 0; m_over = 0;
    m_pend = 0; m_side = 0; m_due = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      restore_game();
      m_gen = GSEED;
      for (int i = 0; i < 3; i++) begin m_low[i] = 0; m_pp[i] = 0; end
    end else begin : step
      bit pl, pr, prs, rnd, chop;
      logic [2:0] btn;
      pl = m_pp[0]; pr = m_pp[1]; prs = m_pp[2];
      btn = {b3, b2, b1};
      for (int i = 0; i < 3; i++) begin
        m_pp[i] = 0;
        if (!btn[i]) m_low[i]++;
        else begin m_pp[i] = (m_low[i] >= int'(DEB)); m_low[i] = 0; end
      end
      rnd = m_gen[0];
`ifdef TB_LFSR_EN
      m_gen = {^(m_gen & 16'h002D), m_gen[15:1]};
`else
      m_gen = {m_gen[1:0], ~m_gen[5:2]};
`endif
      chop = pl | pr;
      if (prs) restore_game();
      else if (m_state == 0) begin
        if (chop) begin m_state = 1; m_pend = 1; m_side = !pl; end
      end else if (m_state == 1) begin
        if (m_due || m_time == 0) begin
          m_state = 2; m_over = 1; m_pend = 0; m_due = 0;
        end else begin
          m_due = 0;
          m_presc++;
          if (m_presc == int'(CLK_HZ)) begin m_presc = 0; m_time--; end
          if (frame_tick && m_pend) begin
            m_player = m_side;
            m_left   = {m_left[8:0], rnd};
            m_right  = {m_right[8:0], ~rnd};
            if (m_score < 99) m_score++;
            m_pend = 0;
            m_due  = (m_left[6] && !m_player) || (m_right[6] && m_player);
          end else if (chop && !m_pend) begin
            m_pend = 1; m_side = !pl;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("left_branch", left_branch, m_left);
    check("right_branch", right_branch, m_right);
    check("player_pos", player_pos, m_player);
    check("game_over", game_over, m_over);
    check("score_tens", score_tens, m_score / 10);
    check("score_ones", score_ones, m_score % 10);
    check("time_tens", time_tens, m_time / 10);
    check("time_ones", time_ones, m_time % 10);
    check("state", state, m_state);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic press_btn(input logic [2:0] m);
    b1 = ~m[0]; b2 = ~m[1]; b3 = ~m[2];
    tick(DEB + 1);
    b1 = 1'b1; b2 = 1'b1; b3 = 1'b1;
    tick(3);
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
  endtask

  task automatic lit_reset_values(input string tag);
    check({tag, "_left"}, left_branch, 10'h03A);
    check({tag, "_right"}, right_branch, 10'h005);
    check({tag, "_time"}, {time_tens, time_ones}, 8'h12);
    check({tag, "_score"}, {score_tens, score_ones}, 8'h00);
    check({tag, "_state"}, state, 0);
    check({tag, "_player"}, player_pos, 0);
    check({tag, "_over"}, game_over, 0);
  endtask

  localparam int NCHOP = 6;
  logic [2:0] chop_tbl [NCHOP] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b001, 3'b010};

  initial begin
    rst = 1'b1; b1 = 1'b1; b2 = 1'b1; b3 = 1'b1; frame_tick = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    lit_reset_values("reset");

    frame();
    tick(1);
    lit_reset_values("idle_frame");

    b1 = 1'b0; tick(2); b1 = 1'b1; tick(3);
    check("short_hold_state", state, 0);

    press_btn(3'b001);
    check("first_chop_state", state, 1);
    check("first_chop_score_pre", score_ones, 0);
    frame();
    check("commit_score", {score_tens, score_ones}, 8'h01);
    check("commit_player", player_pos, 0);
    check("commit_left_shift", left_branch[9:1], 9'h03A);
    check("commit_right_shift", right_branch[9:1], 9'h005);
    check("commit_rnd_pair", left_branch[0] ^ right_branch[0], 1);
    check("commit_over_pre", game_over, 0);
    tick(1);
    check("collide_over", game_over, 1);
    check("collide_state", state, 2);

    press_btn(3'b010);
    frame();
    tick(1);
    check("over_frozen_score", score_ones, 1);
    check("over_frozen_player", player_pos, 0);

    press_btn(3'b100);
    lit_reset_values("restart");

    press_btn(3'b010);
    press_btn(3'b010);
    frame();
    check("double_score", {score_tens, score_ones}, 8'h01);
    check("double_player", player_pos, 1);
    tick(2);
    check("double_no_collide", state, 1);
    frame();
    check("no_pending_score", score_ones, 1);

    for (int i = 0; i < NCHOP; i++) begin
      press_btn(chop_tbl[i]);
      frame();
      tick(2);
    end

    press_btn(3'b100);
    press_btn(3'b010);
    press_btn(3'b100);
    frame();
    tick(1);
    lit_reset_values("pend_discard");

    press_btn(3'b010);
    frame();
    check("timeout_commit", score_ones, 1);
    tick(CLK_HZ * GS + 5);
    check("timeout_state", state, 2);
    check("timeout_over", game_over, 1);
    check("timeout_time", {time_tens, time_ones}, 8'h00);
    check("timeout_score", score_ones, 1);

    press_btn(3'b100);
    lit_reset_values("restart2");
    press_btn(3'b010);
    frame();
    tick(15);
    rst = 1'b1;
    #1;
    lit_reset_values("async_rst");
    tick(2);
    rst = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
